// File: rtl/ni_bus_slave_decode.sv
// Wishbone slave front end: decodes a slave ID from the top address bits
// and forwards one registered request to one of SLAVES register-bus slaves.
module ni_bus_slave_decode #(
  parameter int SLAVES         = 3,
  parameter int SLAVE_ID_WIDTH = 4,
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT        = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        wb_addr,
  input  logic [DATA_WIDTH-1:0]        wb_data_in,
  input  logic                         wb_cyc,
  input  logic                         wb_stb,
  input  logic                         wb_we,
  input  logic [3:0]                   wb_sel,
  input  logic [2:0]                   wb_cti,
  input  logic [1:0]                   wb_bte,
  output logic [DATA_WIDTH-1:0]        wb_data_out,
  output logic                         wb_ack,
  output logic                         wb_err,
  output logic                         wb_rty,
  output logic [ADDR_WIDTH-1:0]        bus_addr,
  output logic                         bus_we,
  output logic [SLAVES-1:0]            bus_en,
  output logic [DATA_WIDTH-1:0]        bus_data_in,
  input  logic [SLAVES*DATA_WIDTH-1:0] bus_data_out,
  input  logic [SLAVES-1:0]            bus_ack,
  input  logic [SLAVES-1:0]            bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [SLAVES-1:0]       sel_q;
  logic                    ack_q;
  logic                    err_q;
  logic [CW-1:0]           cnt_q;

  logic [SLAVE_ID_WIDTH-1:0] id;
  logic                      id_ok;
  logic [SLAVES-1:0]         sel_dec;
  logic                      req;
  logic                      hit_ack;
  logic                      hit_err;
  logic                      tmo;
  logic [DATA_WIDTH-1:0]     rsp_data;
  logic                      unused_ok;

  assign unused_ok = ^{wb_sel, wb_cti, wb_bte};

  assign req     = wb_cyc & wb_stb;
  assign id      = wb_addr[ADDR_WIDTH-1 -: SLAVE_ID_WIDTH];
  assign id_ok   = {1'b0, id} < (SLAVE_ID_WIDTH+1)'(SLAVES);
  assign sel_dec = SLAVES'(1) << id;
  assign hit_ack = |(bus_ack & sel_q);
  assign hit_err = |(bus_err & sel_q);
  assign tmo     = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < SLAVES; i++)
      if (sel_q[i])
        rsp_data |= bus_data_out[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req) state_nxt = id_ok ? BUSY : RESP;
      BUSY: begin
        if (!wb_cyc)
          state_nxt = IDLE;
        else if (hit_ack || hit_err || tmo)
          state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (req) begin
            ack_q   <= 1'b0;
            err_q   <= ~id_ok;
            rdata_q <= '0;
            if (id_ok) begin
              addr_q  <= wb_addr;
              we_q    <= wb_we;
              wdata_q <= wb_data_in;
              sel_q   <= sel_dec;
              cnt_q   <= '0;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (wb_cyc) begin
            // a slave error beats its ack; a real ack beats the timeout
            if (hit_err || (tmo && !hit_ack))
              err_q <= 1'b1;
            else if (hit_ack) begin
              ack_q   <= 1'b1;
              rdata_q <= we_q ? '0 : rsp_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_ack      = (state == RESP) & ack_q;
  assign wb_err      = (state == RESP) & err_q;
  assign wb_data_out = wb_ack ? rdata_q : '0;
  assign wb_rty      = 1'b0;
  assign bus_en      = (state == BUSY) ? sel_q : '0;
  assign bus_addr    = addr_q;
  assign bus_we      = we_q;
  assign bus_data_in = wdata_q;

endmodule

// File: tb/tb_ni_bus_slave_decode.sv
// Bench for ni_bus_slave_decode: directed requests, expected
// terminations queued and checked by an independent monitor.
module tb_ni_bus_slave_decode;

  localparam int SL = 3;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data_in;
  logic             wb_cyc, wb_stb, wb_we;
  logic [3:0]       wb_sel;
  logic [2:0]       wb_cti;
  logic [1:0]       wb_bte;
  logic [DW-1:0]    wb_data_out;
  logic             wb_ack, wb_err, wb_rty;
  logic [AW-1:0]    bus_addr;
  logic             bus_we;
  logic [SL-1:0]    bus_en;
  logic [DW-1:0]    bus_data_in;
  logic [SL*DW-1:0] bus_data_out;
  logic [SL-1:0]    bus_ack, bus_err;

  ni_bus_slave_decode #(
    .SLAVES(SL), .SLAVE_ID_WIDTH(4), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_addr(wb_addr), .wb_data_in(wb_data_in),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_data_out(wb_data_out), .wb_ack(wb_ack),
    .wb_err(wb_err), .wb_rty(wb_rty),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   c0;

  task automatic check(string name, logic [DW-1:0] got, logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic start(logic [AW-1:0] a, logic w, logic [DW-1:0] d);
    wb_addr    = a;
    wb_we      = w;
    wb_data_in = d;
    wb_cyc     = 1'b1;
    wb_stb     = 1'b1;
  endtask

  task automatic stop();
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
  endtask

  // monitor: every termination must match the head of the queue
  always @(negedge clk) begin
    if (wb_ack || wb_err) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL term_unexpected ack=%b err=%b data=%h cyc=%0d",
                 wb_ack, wb_err, wb_data_out, cyc);
      end else begin
        e = q.pop_front();
        if (wb_err !== e.err || wb_ack !== !e.err ||
            wb_data_out !== e.data || cyc != e.at) begin
          bad++;
          $display("FAIL term got ack=%b err=%b data=%h cyc=%0d want err=%b data=%h cyc=%0d",
                   wb_ack, wb_err, wb_data_out, cyc, e.err, e.data, e.at);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    wb_addr = '0; wb_data_in = '0; wb_we = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    wb_sel = 4'hF; wb_cti = '0; wb_bte = '0;
    bus_data_out = '0; bus_ack = '0; bus_err = '0;
    #3;
    check("rst_ack_err", {30'd0, wb_ack, wb_err}, 32'd0);
    check("rst_rdata", wb_data_out, 32'd0);
    check("rst_en", 32'(bus_en), 32'd0);
    check("rst_addr", 32'(bus_addr), 32'd0);
    check("rst_wdata", bus_data_in, 32'd0);
    check("rst_we_rty", {30'd0, bus_we, wb_rty}, 32'd0);
    nxt(); nxt();
    rst = 1'b1;
    nxt();

    // write to slave 1, ack in first enabled cycle
    c0 = cyc;
    start(24'h100004, 1'b1, 32'hDEADBEEF);
    q.push_back('{1'b0, 32'd0, c0 + 2});
    nxt();
    check("wr_en", 32'(bus_en), 32'h2);
    check("wr_addr", 32'(bus_addr), 32'h100004);
    check("wr_wdata", bus_data_in, 32'hDEADBEEF);
    check("wr_we", 32'(bus_we), 32'd1);
    bus_ack = 3'b010;
    nxt();
    bus_ack = '0;
    check("wr_en_off", 32'(bus_en), 32'd0);
    stop();
    nxt();
    check("wr_idle_en", 32'(bus_en), 32'd0);
    check("idle_rdata", wb_data_out, 32'd0);

    // read slave 2 after 3 wait cycles; other slaves' responses ignored
    c0 = cyc;
    start(24'h200010, 1'b0, 32'hCAFEF00D);
    q.push_back('{1'b0, 32'h12345678, c0 + 5});
    bus_data_out[0 +: DW] = 32'hFFFF0000;
    nxt();
    check("rd_en", 32'(bus_en), 32'h4);
    check("rd_we", 32'(bus_we), 32'd0);
    check("rd_wdata", bus_data_in, 32'hCAFEF00D);
    nxt();
    bus_ack = 3'b011;
    bus_err = 3'b001;
    nxt();
    bus_ack = '0;
    bus_err = '0;
    nxt();
    check("rd_en_wait", 32'(bus_en), 32'h4);
    bus_data_out[2*DW +: DW] = 32'h12345678;
    bus_ack = 3'b100;
    nxt();
    bus_ack = '0;
    stop();
    nxt();

    // invalid IDs 3 and 15
    c0 = cyc;
    start(24'h300000, 1'b0, 32'd0);
    q.push_back('{1'b1, 32'd0, c0 + 1});
    nxt();
    check("inv3_en", 32'(bus_en), 32'd0);
    check("inv3_addr_hold", 32'(bus_addr), 32'h200010);
    stop();
    nxt();
    c0 = cyc;
    start(24'hF00000, 1'b1, 32'h1);
    q.push_back('{1'b1, 32'd0, c0 + 1});
    nxt();
    check("inv15_en", 32'(bus_en), 32'd0);
    stop();
    nxt();

    // slave 0 raises err and ack together
    c0 = cyc;
    start(24'h000040, 1'b0, 32'd0);
    q.push_back('{1'b1, 32'd0, c0 + 2});
    nxt();
    check("err_en", 32'(bus_en), 32'h1);
    bus_data_out[0 +: DW] = 32'hAAAA5555;
    bus_ack = 3'b001;
    bus_err = 3'b001;
    nxt();
    bus_ack = '0;
    bus_err = '0;
    stop();
    nxt();

    // slave 1 silent: timeout
    c0 = cyc;
    start(24'h100000, 1'b1, 32'h5);
    q.push_back('{1'b1, 32'd0, c0 + TO + 1});
    for (int k = 1; k <= TO; k++) begin
      nxt();
      check($sformatf("tmo_en_%0d", k), 32'(bus_en), 32'h2);
    end
    nxt();
    check("tmo_en_off", 32'(bus_en), 32'd0);
    stop();
    nxt();

    // master abort during BUSY
    start(24'h000008, 1'b0, 32'd0);
    nxt();
    check("abt_en1", 32'(bus_en), 32'h1);
    nxt();
    check("abt_en2", 32'(bus_en), 32'h1);
    stop();
    nxt();
    check("abt_en_off", 32'(bus_en), 32'd0);
    nxt(); nxt();

    // reset during BUSY
    start(24'h200000, 1'b1, 32'h77);
    nxt();
    check("rstb_en", 32'(bus_en), 32'h4);
    rst = 1'b0;
    #1;
    check("rstb_en_off", 32'(bus_en), 32'd0);
    check("rstb_term", {30'd0, wb_ack, wb_err}, 32'd0);
    check("rstb_addr", 32'(bus_addr), 32'd0);
    stop();
    nxt();
    rst = 1'b1;
    nxt();

    // normal read after reset
    c0 = cyc;
    start(24'h100008, 1'b0, 32'd0);
    q.push_back('{1'b0, 32'h0BADF00D, c0 + 2});
    nxt();
    check("post_en", 32'(bus_en), 32'h2);
    bus_data_out[DW +: DW] = 32'h0BADF00D;
    bus_ack = 3'b010;
    nxt();
    bus_ack = '0;
    stop();
    nxt();

    // back-to-back with strobe held through RESP
    c0 = cyc;
    start(24'h000010, 1'b1, 32'h11);
    q.push_back('{1'b0, 32'd0, c0 + 2});
    q.push_back('{1'b0, 32'd0, c0 + 5});
    nxt();
    bus_ack = 3'b001;
    nxt();
    bus_ack = '0;
    start(24'h200020, 1'b1, 32'h22);
    nxt();
    check("b2b_idle_en", 32'(bus_en), 32'd0);
    nxt();
    check("b2b_en", 32'(bus_en), 32'h4);
    check("b2b_addr", 32'(bus_addr), 32'h200020);
    bus_ack = 3'b100;
    nxt();
    bus_ack = '0;
    stop();
    nxt(); nxt(); nxt();

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ni_bus_slave_decode.md
# ni_bus_slave_decode

Wishbone B3 slave front end of the network interface that splits one bus port into SLAVES generic register-bus slaves (config, BE channels, TDM channels). It decodes the slave ID from the top address bits, registers the request, drives exactly one slave enable and returns a one-cycle registered ack or error to the master. Invalid IDs, slave errors and unresponsive slaves all terminate as a bus error.

## Interface
- SLAVES, 3, number of attached slaves; IDs 0..SLAVES-1.
- SLAVE_ID_WIDTH, 4, width of the ID field at wb_addr[ADDR_WIDTH-1 -: SLAVE_ID_WIDTH].
- ADDR_WIDTH, 24, decoded address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT, 256, max BUSY cycles before forced error; 0 disables.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- wb_addr  in  ADDR_WIDTH  request address.
- wb_data_in  in  DATA_WIDTH  write data.
- wb_cyc, wb_stb, wb_we  in  1 each  Wishbone cycle, strobe, write enable.
- wb_sel  in  4 / wb_cti  in  3 / wb_bte  in  2  ignored.
- wb_data_out  out  DATA_WIDTH  read data, valid with wb_ack.
- wb_ack, wb_err  out  1 each  one-cycle termination.
- wb_rty  out  1  tied 0.
- bus_addr  out  ADDR_WIDTH  registered full address (ID bits included).
- bus_we  out  1  registered write enable.
- bus_en  out  SLAVES  one-hot slave enable.
- bus_data_in  out  DATA_WIDTH  registered write data.
- bus_data_out  in  SLAVES×DATA_WIDTH  per-slave read data.
- bus_ack, bus_err  in  SLAVES each  per-slave termination.

## Operation
- FSM states IDLE, BUSY, RESP.
- IDLE: when wb_cyc & wb_stb, compute id from ID field. id < SLAVES: latch addr, we, data, id; clear timeout counter; go BUSY. id ≥ SLAVES: set error flag, go RESP; no bus_en.
- BUSY: bus_en[id]=1, all others 0. bus_ack[id] → latch bus_data_out[id] (reads; writes latch 0), set ack flag, go RESP. bus_err[id] → error flag, go RESP; err wins if both. Inputs from other slaves ignored. Counter increments each BUSY cycle; TIMEOUT≠0 and counter reaches TIMEOUT-1 without response → error flag, go RESP.
- BUSY with wb_cyc=0 (master abort): go IDLE, drop bus_en, no ack/err.
- RESP: wb_ack or wb_err high exactly one cycle; wb_data_out = latched data when ack, else 0; go IDLE unconditionally.
- Outside RESP: wb_ack=wb_err=0, wb_data_out=0.
- bus_addr/bus_we/bus_data_in hold last latched value until the next request.
- Only one transaction in flight; no pipelining.

## Timing
- Reset (rst=0, async): state IDLE; all outputs 0, bus_en=0, counter 0.
- Request sampled on edge E0; bus_en high from E0 through the edge where the slave responds.
- Slave responding combinationally in its first enabled cycle: wb_ack/wb_err high in cycle 2 after strobe (strobe cycle 0, bus_en cycle 1, ack cycle 2).
- Invalid ID: wb_err in cycle 1.
- Timeout: wb_err in cycle TIMEOUT+1.
- After RESP, a strobe held in the next cycle starts a new transaction (back-to-back rate: one per 3 cycles minimum).
- Reset mid-transaction aborts immediately; no termination is issued.

## Test plan
- Write wb_addr=0x100004, data 0xDEADBEEF, slave 1 acks in first enabled cycle -> bus_en=3'b010 one cycle, bus_addr=0x100004, bus_data_in=0xDEADBEEF, bus_we=1, wb_ack in cycle 2.
- Read 0x200010, slave 2 returns 0x12345678 after 3 wait cycles -> wb_ack one cycle with wb_data_out=0x12345678, cycle 5.
- Access 0x300000 (ID 3) -> wb_err in cycle 1, bus_en stays 0.
- Slave 0 raises bus_err (and bus_ack same cycle) -> wb_err only, wb_ack 0.
- TIMEOUT=8, slave 1 silent -> bus_en[1] high 8 cycles, wb_err in cycle 9; wb_cyc drop during BUSY -> bus_en cleared next edge, no termination.
- Assert rst during BUSY -> all outputs 0 immediately; next request decoded normally.
